// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. Accepts two WIDTH-bit operands, adds one
// bit pair per clock (LSB first) through a registered carry, then presents
// the WIDTH-bit sum and the final carry until downstream takes them.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The source holds valid (and data) until that edge. Ready may
// be sampled freely and never depends on valid. Outputs (out_valid, result,
// carry_out) stay stable while out_valid is high and out_ready is low.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_nxt;

  // One full-adder step on the current LSB pair and the registered carry.
  always_comb begin
    sum_bit   = shift_a[0] ^ shift_b[0] ^ c;
    carry_nxt = (shift_a[0] & shift_b[0]) | (shift_a[0] & c) | (shift_b[0] & c);
  end

  // Ready only in IDLE, and forced low while reset is held.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign result   = acc;

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_a   <= '0;
      shift_b   <= '0;
      acc       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_a <= op_a;
            shift_b <= op_b;
            acc     <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          c       <= carry_nxt;
          acc     <= {sum_bit, acc[WIDTH-1:1]};
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            carry_out <= carry_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder (WIDTH=8)
// against a plain-arithmetic reference model and an expected queue.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         busy;

  logic [W:0]   exp_q[$];
  int           n_checks;
  int           n_errors;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned s;
    s = int'(a) + int'(b);
    return s[W:0];
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, optional ignored in_valid noise while busy,
  // `hold` cycles of backpressure, then handshake.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit noise);
    int n;
    int lat;
    logic [W-1:0] r0;
    logic         c0;
    logic [W:0]   e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    exp_q.push_back(ref_sum(a, b));
    tick();
    in_valid = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        op_a     = 8'h11;
      end
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(W));
    check("busy_done", 32'(busy), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    r0 = result;
    c0 = carry_out;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        op_a     = 8'h11;
      end
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'({carry_out, result}), 32'({c0, r0}));
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    check("sum", 32'({carry_out, result}), 32'(e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("result_retained", 32'({carry_out, result}), 32'(e));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc_t[$];
    int cyc;
    int n;
    logic [W:0] e;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({out_valid, carry_out, busy, result}), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_release", 32'(in_ready), 32'd1);

    // directed vectors
    do_op(8'h00, 8'h00, 0, 1'b0);
    do_op(8'h5A, 8'h3C, 0, 1'b0);
    do_op(8'hFF, 8'h01, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 0, 1'b0);

    // backpressure for 5 cycles with ignored in_valid pulses
    do_op(8'h2B, 8'h47, 5, 1'b1);

    // out_ready pulse while idle has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_pulse", 32'({out_valid, in_ready}), 32'b01);

    // asynchronous reset during the 4th SHIFT cycle
    in_valid = 1'b1;
    op_a     = 8'hFF;
    op_b     = 8'h00;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", 32'({out_valid, carry_out, busy, result}), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);
    do_op(8'h80, 8'h80, 0, 1'b0);

    // random sweep with random backpressure and noise
    for (int i = 0; i < 500; i++) begin
      do_op(W'($urandom), W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // back-to-back with in_valid and out_ready held high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op_a      = W'($urandom);
    op_b      = W'($urandom);
    cyc = 0;
    while (acc_t.size() < 4 && cyc < 200) begin
      logic took;
      took = in_valid && in_ready;
      if (took) begin
        acc_t.push_back(cyc);
        exp_q.push_back(ref_sum(op_a, op_b));
      end
      if (out_valid) begin
        check("b2b_in_ready_done", 32'(in_ready), 32'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("b2b_sum", 32'({carry_out, result}), 32'(e));
      end
      tick();
      cyc++;
      if (took) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(acc_t.size()), 32'd4);
    for (int i = 1; i < acc_t.size(); i++) begin
      check("b2b_gap", 32'(acc_t[i] - acc_t[i-1]), 32'(W + 2));
    end
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        check("b2b_drain_sum", 32'({carry_out, result}), 32'(e));
      end
      tick();
      n++;
    end
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder stage that sits directly upstream of the half-adder datapath in the arithmetic chain. It accepts two WIDTH-bit operands over a valid/ready handshake and processes them one bit pair per cycle, LSB first. A registered carry makes each step a full add. It assembles the WIDTH-bit sum plus final carry and presents them over an output valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, operand and result width; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair on op_a/op_b is valid.
- in_ready  output  1  block can accept operands; equals (state==IDLE) && !rst.
- op_a  input  WIDTH  first operand.
- op_b  input  WIDTH  second operand.
- out_valid  output  1  result/carry_out valid; registered.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  sum bits [WIDTH-1:0]; registered.
- carry_out  output  1  carry out of the MSB; registered.
- busy  output  1  high in SHIFT or DONE.

## Operation
- State machine has three states:
  - IDLE (in_ready=1).
  - SHIFT (serial add in progress).
  - DONE (out_valid=1).
- Internal registers:
  - shift_a and shift_b, WIDTH bits each.
  - acc, WIDTH bits, drives result.
  - c, 1 bit.
  - cnt, clog2(WIDTH+1) bits.
- IDLE -> SHIFT on in_valid && in_ready:
  - load shift_a=op_a and shift_b=op_b;
  - set c=0 and cnt=0;
  - clear acc.
- Each SHIFT edge:
  - compute s = shift_a[0]^shift_b[0]^c;
  - c <= majority(shift_a[0], shift_b[0], c);
  - acc <= {s, acc[WIDTH-1:1]};
  - shift_a and shift_b shift right by 1 with zero fill;
  - cnt <= cnt+1.
- SHIFT -> DONE on the edge where cnt==WIDTH-1, i.e. after the WIDTH-th bit is processed. On that same edge:
  - carry_out <= next value of c;
  - out_valid <= 1.
- DONE -> IDLE on out_ready: out_valid <= 0.
  - A new operand is not accepted in the same cycle. in_ready rises the cycle after.
- Arithmetic:
  - {carry_out, result} == op_a + op_b, exact, modulo 2^(WIDTH+1).
  - No overflow flag beyond carry_out.
- in_valid while busy is ignored; operands are not latched.
- result and carry_out hold stable for the whole time out_valid is high, and retain their last value after the handshake until the next load.
- op_a and op_b are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset, asynchronous, any time:
  - state=IDLE;
  - out_valid=0, result=0, carry_out=0, busy=0;
  - shift_a, shift_b, acc, c and cnt all 0;
  - in_ready=0 while rst is high, 1 from the first cycle after release.
- Reset mid-SHIFT or mid-DONE aborts the operation. No partial result is ever presented.
- Latency:
  - accept edge at T0;
  - bit k is processed at edge T0+k+1, for k=0..WIDTH-1;
  - out_valid is high from edge T0+WIDTH.
- Throughput: one operation per WIDTH+2 cycles with out_ready held high. The cycles are:
  - accept;
  - WIDTH shift cycles, the last ending in DONE;
  - one DONE cycle;
  - one IDLE cycle before the next accept.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- An out_ready pulse while out_valid=0 has no effect.

## Test plan
- Reset with WIDTH=8, then op_a=0x00, op_b=0x00 -> out_valid exactly 8 cycles after accept, result=0x00, carry_out=0.
- op_a=0x5A, op_b=0x3C -> result=0x96, carry_out=0. Then op_a=0xFF, op_b=0x01 -> result=0x00, carry_out=1.
- op_a=0xFF, op_b=0xFF -> result=0xFE, carry_out=1. Also run a 500-pair random sweep checked against a full-width add, with random out_ready backpressure.
- Hold out_ready low for 5 cycles after out_valid -> result, carry_out and out_valid stay unchanged. in_valid pulses with op_a=0x11 during SHIFT and DONE are ignored: next result still matches the first operand pair.
- Assert rst at the 4th SHIFT cycle -> all outputs 0 immediately (asynchronous). After release, in_ready=1, and a new pair 0x80+0x80 gives result=0x00, carry_out=1.
- Back-to-back operations with in_valid and out_ready held high -> accepts are exactly 10 cycles apart for WIDTH=8, and in_ready=0 in the DONE→IDLE handoff cycle.
